// File: rtl/sdram_responder.sv
// sdram_responder: device-side model of a 32-bit SDRAM for simulation and
// FPGA loopback benches. Decodes the controller's command pins each rising
// edge. It tracks open rows per bank and the mode register, and stores write
// bursts in an internal array. Read bursts come back after the programmed
// CAS latency. Protocol violations from the controller are flagged.
//
// Ports:
//   clk, n_rst                  clock, synchronous active-low reset
//   cke, cs_n, ras_n, cas_n, we_n  command pins
//   dqmh, dqml                  byte-lane masks (1 = masked), high/low 16 bits
//   ba, addr                    bank, row/column/mode address
//   dq_in                       write data from the controller
//   dq_out, rd_valid            read data; rd_valid qualifies dq_out for the
//                               cycle (no back-pressure, dq_out is 0 otherwise)
//   cmd_err                     one-cycle pulse after an illegal command edge
//   mode_set                    mode register loaded since reset
//   self_ref                    device is in self-refresh
module sdram_responder #(
    parameter int ROW_BITS = 3,
    parameter int COL_BITS = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cke,
    input  logic        cs_n,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic        dqmh,
    input  logic        dqml,
    input  logic [1:0]  ba,
    input  logic [12:0] addr,
    input  logic [31:0] dq_in,
    output logic [31:0] dq_out,
    output logic        rd_valid,
    output logic        cmd_err,
    output logic        mode_set,
    output logic        self_ref
);
    localparam int AW    = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH = 2 ** AW;

    localparam logic [2:0] CMD_MRS = 3'b000;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_BURST_RD, S_BURST_WR, S_SELF_REF
    } state_t;

    // state is kept as a named register so checkers can bind to it directly
    state_t state, state_nx;

    logic [31:0]         mem [DEPTH];
    logic [3:0]          open_q;
    logic [ROW_BITS-1:0] row_q [4];
    logic                cl3_q;   // 1: CAS latency 3, 0: CAS latency 2
    logic                bl4_q;   // 1: burst length 4, 0: burst length 1
    logic [1:0]          bst_bank;
    logic [COL_BITS-1:0] bst_col;
    logic [1:0]          bst_cnt;
    logic                bst_ap;
    logic                s0_v, s1_v;
    logic [31:0]         s0_d, s1_d;

    logic [2:0] cmd;
    logic       sel, is_sre, mrs_ok;
    logic       err, start_rd, start_wr, do_act, do_pre, do_mrs;
    logic       in_burst, beat_rd, beat_wr, beat_last, beat_ap;
    logic [1:0]          beat_bank;
    logic [COL_BITS-1:0] beat_col, next_col;
    logic [AW-1:0]       beat_idx;
    logic [31:0]         mem_word, rd_word;
    logic                unused_addr;

    assign unused_addr = ^addr;

    assign cmd    = {ras_n, cas_n, we_n};
    assign sel    = !cs_n && (cmd != 3'b111);
    assign is_sre = sel && !cke && (cmd == CMD_REF);
    assign mrs_ok = (addr[6:4] == 3'd2 || addr[6:4] == 3'd3) &&
                    (addr[2:0] == 3'd0 || addr[2:0] == 3'd2);

    always_comb begin
        state_nx = state;
        err      = 1'b0;
        start_rd = 1'b0;
        start_wr = 1'b0;
        do_act   = 1'b0;
        do_pre   = 1'b0;
        do_mrs   = 1'b0;
        case (state)
            S_INIT: begin
                if (sel && !is_sre && cmd == CMD_MRS) begin
                    if (mrs_ok) begin
                        do_mrs   = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        err = 1'b1;
                    end
                end else if (sel && (is_sre || (cmd != CMD_PRE && cmd != CMD_REF))) begin
                    err = 1'b1;
                end
            end
            S_IDLE: begin
                if (is_sre) begin
                    state_nx = S_SELF_REF;
                end else if (sel) begin
                    case (cmd)
                        CMD_ACT: begin
                            if (open_q[ba]) err = 1'b1;
                            else            do_act = 1'b1;
                        end
                        CMD_RD, CMD_WR: begin
                            if (!open_q[ba]) begin
                                err = 1'b1;
                            end else begin
                                start_rd = (cmd == CMD_RD);
                                start_wr = (cmd == CMD_WR);
                                if (bl4_q)
                                    state_nx = (cmd == CMD_RD) ? S_BURST_RD : S_BURST_WR;
                            end
                        end
                        CMD_PRE: do_pre = 1'b1;
                        CMD_REF: err = |open_q;
                        default: begin
                            if ((|open_q) || !mrs_ok) err = 1'b1;
                            else                      do_mrs = 1'b1;
                        end
                    endcase
                end
            end
            S_BURST_RD, S_BURST_WR: begin
                err = sel;
                if (bst_cnt == 2'd3) state_nx = S_IDLE;
            end
            S_SELF_REF: begin
                if (cke) state_nx = S_IDLE;
            end
            default: state_nx = S_INIT;
        endcase
    end

    // Beat 0 uses the command's own bank/column; later beats use the latched burst.
    assign in_burst  = (state == S_BURST_RD) || (state == S_BURST_WR);
    assign beat_rd   = start_rd || (state == S_BURST_RD);
    assign beat_wr   = start_wr || (state == S_BURST_WR);
    assign beat_bank = in_burst ? bst_bank : ba;
    assign beat_col  = in_burst ? bst_col : addr[COL_BITS-1:0];
    assign beat_ap   = in_burst ? bst_ap : addr[10];
    assign beat_last = in_burst ? (bst_cnt == 2'd3) : !bl4_q;
    assign beat_idx  = {beat_bank, row_q[beat_bank], beat_col};
    // wrap within the 4-aligned block
    assign next_col  = {beat_col[COL_BITS-1:2], beat_col[1:0] + 2'd1};
    assign mem_word  = mem[beat_idx];
    assign rd_word   = {dqmh ? 16'h0000 : mem_word[31:16],
                        dqml ? 16'h0000 : mem_word[15:0]};
    assign self_ref  = (state == S_SELF_REF);

    always_ff @(posedge clk) begin
        if (n_rst && beat_wr) begin
            if (!dqml) mem[beat_idx][15:0]  <= dq_in[15:0];
            if (!dqmh) mem[beat_idx][31:16] <= dq_in[31:16];
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= S_INIT;
            cmd_err  <= 1'b0;
            mode_set <= 1'b0;
            cl3_q    <= 1'b1;
            bl4_q    <= 1'b0;
            open_q   <= 4'b0000;
            bst_bank <= 2'd0;
            bst_col  <= '0;
            bst_cnt  <= 2'd0;
            bst_ap   <= 1'b0;
            s0_v     <= 1'b0;
            s0_d     <= 32'h0;
            s1_v     <= 1'b0;
            s1_d     <= 32'h0;
            rd_valid <= 1'b0;
            dq_out   <= 32'h0;
        end else begin
            state   <= state_nx;
            cmd_err <= err;
            if (do_mrs) begin
                cl3_q    <= addr[4];
                bl4_q    <= addr[1];
                mode_set <= 1'b1;
            end
            if (do_act) begin
                open_q[ba] <= 1'b1;
                row_q[ba]  <= addr[ROW_BITS-1:0];
            end
            if (do_pre) begin
                if (addr[10]) open_q     <= 4'b0000;
                else          open_q[ba] <= 1'b0;
            end
            if ((beat_rd || beat_wr) && beat_last && beat_ap)
                open_q[beat_bank] <= 1'b0;
            if (start_rd || start_wr) begin
                bst_bank <= ba;
                bst_ap   <= addr[10];
                bst_col  <= next_col;
                bst_cnt  <= 2'd1;
            end else if (in_burst) begin
                bst_col <= next_col;
                bst_cnt <= bst_cnt + 2'd1;
            end
            // CL3 beats enter at stage 0, CL2 beats skip straight to stage 1;
            // invalid stages always carry zero so they can be OR-merged.
            s0_v     <= beat_rd && cl3_q;
            s0_d     <= (beat_rd && cl3_q) ? rd_word : 32'h0;
            s1_v     <= s0_v || (beat_rd && !cl3_q);
            s1_d     <= s0_d | ((beat_rd && !cl3_q) ? rd_word : 32'h0);
            rd_valid <= s1_v;
            dq_out   <= s1_d;
        end
    end
endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed scenarios with literal expectations,
// then randomized command traffic. A behavioural model predicts every output
// each cycle from absolute edge numbers and a word-addressed memory.
module tb_sdram_responder;
    logic        clk, n_rst, cke, cs_n, ras_n, cas_n, we_n, dqmh, dqml;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [31:0] dq_in, dq_out;
    logic        rd_valid, cmd_err, mode_set, self_ref;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010,
                           C_ACT = 3'b011, C_WR  = 3'b100, C_RD  = 3'b101,
                           C_NOP = 3'b111;

    sdram_responder #(.ROW_BITS(3), .COL_BITS(4)) dut (
        .clk(clk), .n_rst(n_rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
        .cas_n(cas_n), .we_n(we_n), .dqmh(dqmh), .dqml(dqml), .ba(ba),
        .addr(addr), .dq_in(dq_in), .dq_out(dq_out), .rd_valid(rd_valid),
        .cmd_err(cmd_err), .mode_set(mode_set), .self_ref(self_ref)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int e;
        bit wr;
        int idx;
    } beat_t;

    int          edge_n = 0;
    bit          started = 0;
    bit          m_init, m_sr, m_mode_set, m_err;
    int          m_cl, m_bl, busy_until;
    bit          m_open [4];
    int          m_row [4];
    int          m_close_at [4];
    beat_t       pend [$];
    logic [31:0] m_mem [int];
    logic [1:0]  m_known [int];
    bit          exp_v [int];
    logic [31:0] exp_d [int];
    logic [31:0] exp_m [int];

    function automatic bit mrs_legal(input logic [12:0] a);
        return (a[6:4] == 2 || a[6:4] == 3) && (a[2:0] == 0 || a[2:0] == 2);
    endfunction

    function automatic bit any_open();
        return m_open[0] | m_open[1] | m_open[2] | m_open[3];
    endfunction

    always @(posedge clk) begin : model
        int c, col_k, ci;
        bit sel, err;
        beat_t bt;
        logic [31:0] d, m;
        edge_n++;
        if (!n_rst) begin
            started = 1; m_init = 1; m_sr = 0; m_mode_set = 0; m_err = 0;
            m_cl = 3; m_bl = 1; busy_until = -1;
            for (int b = 0; b < 4; b++) begin m_open[b] = 0; m_close_at[b] = -1; end
            pend.delete(); exp_v.delete(); exp_d.delete(); exp_m.delete();
        end else begin
            c = int'({ras_n, cas_n, we_n});
            sel = !cs_n && c != 7;
            err = 0;
            if (m_sr) begin
                if (cke) m_sr = 0;
            end else if (edge_n <= busy_until) begin
                err = sel;
            end else if (sel) begin
                if (!cke && c == 1) begin
                    if (m_init) err = 1; else m_sr = 1;
                end else if (m_init) begin
                    if (c == 0) begin
                        if (mrs_legal(addr)) begin
                            m_cl = int'(addr[6:4]); m_bl = (addr[2:0] == 0) ? 1 : 4;
                            m_mode_set = 1; m_init = 0;
                        end else err = 1;
                    end else if (c != 2 && c != 1) err = 1;
                end else begin
                    case (c)
                        3: if (m_open[ba]) err = 1;
                           else begin m_open[ba] = 1; m_row[ba] = int'(addr[2:0]); end
                        4, 5: if (!m_open[ba]) err = 1;
                           else begin
                               ci = int'(addr[3:0]);
                               for (int k = 0; k < m_bl; k++) begin
                                   col_k = (ci & 12) | ((ci + k) & 3);
                                   pend.push_back('{e: edge_n + k, wr: (c == 4),
                                                    idx: int'(ba) * 128 + m_row[ba] * 16 + col_k});
                               end
                               busy_until = edge_n + m_bl - 1;
                               if (addr[10]) m_close_at[ba] = edge_n + m_bl - 1;
                           end
                        2: if (addr[10]) for (int b = 0; b < 4; b++) m_open[b] = 0;
                           else m_open[ba] = 0;
                        1: err = any_open();
                        default: if (any_open() || !mrs_legal(addr)) err = 1;
                           else begin m_cl = int'(addr[6:4]); m_bl = (addr[2:0] == 0) ? 1 : 4; end
                    endcase
                end
            end
            m_err = err;
            while (pend.size() > 0 && pend[0].e == edge_n) begin
                bt = pend.pop_front();
                if (!m_mem.exists(bt.idx)) begin m_mem[bt.idx] = 0; m_known[bt.idx] = 0; end
                if (bt.wr) begin
                    if (!dqml) begin m_mem[bt.idx][15:0]  = dq_in[15:0];  m_known[bt.idx][0] = 1; end
                    if (!dqmh) begin m_mem[bt.idx][31:16] = dq_in[31:16]; m_known[bt.idx][1] = 1; end
                end else begin
                    d = m_mem[bt.idx];
                    m[15:0]  = m_known[bt.idx][0] ? 16'hFFFF : 16'h0000;
                    m[31:16] = m_known[bt.idx][1] ? 16'hFFFF : 16'h0000;
                    if (dqml) begin d[15:0]  = 16'h0; m[15:0]  = 16'hFFFF; end
                    if (dqmh) begin d[31:16] = 16'h0; m[31:16] = 16'hFFFF; end
                    exp_v[edge_n + m_cl - 1] = 1;
                    exp_d[edge_n + m_cl - 1] = d;
                    exp_m[edge_n + m_cl - 1] = m;
                end
            end
            for (int b = 0; b < 4; b++)
                if (m_close_at[b] == edge_n) begin m_open[b] = 0; m_close_at[b] = -1; end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        bit ev;
        logic [31:0] ed, em;
        if (started) begin
            ev = exp_v.exists(edge_n);
            ed = ev ? exp_d[edge_n] : 32'h0;
            em = ev ? exp_m[edge_n] : 32'hFFFF_FFFF;
            chk("rd_valid", 32'(rd_valid), 32'(ev));
            chk("dq_out", dq_out & em, ed & em);
            chk("cmd_err", 32'(cmd_err), 32'(m_err));
            chk("mode_set", 32'(mode_set), 32'(m_mode_set));
            chk("self_ref", 32'(self_ref), 32'(m_sr));
            if (ev) begin exp_v.delete(edge_n); exp_d.delete(edge_n); exp_m.delete(edge_n); end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic [31:0] d, input logic mh, input logic ml, input logic ck);
        @(negedge clk);
        n_rst = 1'b1; cs_n = 1'b0; {ras_n, cas_n, we_n} = c;
        ba = b; addr = a; dq_in = d; dqmh = mh; dqml = ml; cke = ck;
    endtask

    task automatic nop();
        drive(C_NOP, 2'd0, 13'd0, $urandom(), 1'b0, 1'b0, 1'b1);
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
        drive(c, b, a, $urandom(), 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin nop(); n_rst = 1'b0; end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [12:0] a;
        logic [1:0]  b;
        int r;
        n_rst = 1'b0; cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP; cke = 1'b1;
        dqmh = 1'b0; dqml = 1'b0; ba = 2'd0; addr = 13'd0; dq_in = 32'd0;

        // reset, then CL3/BL1 write and auto-precharge read-back
        do_reset(2);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset dq_out", dq_out, 32'd0);
        chk("reset mode_set", 32'(mode_set), 32'd0);
        cmd(C_MRS, 2'd0, 13'h030);
        cmd(C_ACT, 2'd1, 13'd5);
        chk("mrs mode_set", 32'(mode_set), 32'd1);
        drive(C_WR, 2'd1, 13'h403, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
        cmd(C_ACT, 2'd1, 13'd5);
        cmd(C_RD, 2'd1, 13'h403);
        nop(); chk("t1 rv N", 32'(rd_valid), 32'd0);
        nop(); chk("t1 rv N+1", 32'(rd_valid), 32'd0);
        nop(); chk("t1 rv N+2", 32'(rd_valid), 32'd1);
        chk("t1 data", dq_out, 32'hDEADBEEF);
        nop(); chk("t1 rv N+3", 32'(rd_valid), 32'd0);

        // CL3/BL4 wrapped burst starting at column 6
        cmd(C_MRS, 2'd0, 13'h032);
        cmd(C_ACT, 2'd0, 13'd2);
        drive(C_WR, 2'd0, 13'h006, 32'hA000_000A, 1'b0, 1'b0, 1'b1);
        drive(C_NOP, 2'd0, 13'd0, 32'hB000_000B, 1'b0, 1'b0, 1'b1);
        drive(C_NOP, 2'd0, 13'd0, 32'hC000_000C, 1'b0, 1'b0, 1'b1);
        drive(C_NOP, 2'd0, 13'd0, 32'hD000_000D, 1'b0, 1'b0, 1'b1);
        cmd(C_RD, 2'd0, 13'h406);
        nop(); nop();
        nop(); chk("t2 beat A", dq_out, 32'hA000_000A);
        nop(); chk("t2 beat B", dq_out, 32'hB000_000B);
        nop(); chk("t2 beat C", dq_out, 32'hC000_000C);
        nop(); chk("t2 beat D", dq_out, 32'hD000_000D);
        nop(); chk("t2 end rv", 32'(rd_valid), 32'd0);

        // byte-lane masks on write and read
        cmd(C_MRS, 2'd0, 13'h030);
        cmd(C_ACT, 2'd2, 13'd1);
        drive(C_WR, 2'd2, 13'h000, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b1);
        drive(C_WR, 2'd2, 13'h000, 32'h11223344, 1'b1, 1'b0, 1'b1);
        cmd(C_RD, 2'd2, 13'h000);
        drive(C_RD, 2'd2, 13'h000, 32'h0, 1'b0, 1'b1, 1'b1);
        nop();
        nop(); chk("t3 dqmh write", dq_out, 32'hAAAA3344);
        nop(); chk("t3 dqml read", dq_out, 32'hAAAA0000);

        // protocol violations
        cmd(C_RD, 2'd3, 13'h000);
        nop(); chk("t4 read closed", 32'(cmd_err), 32'd1);
        nop(); chk("t4 err pulse", 32'(cmd_err), 32'd0);
        cmd(C_ACT, 2'd2, 13'd1);
        nop(); chk("t4 act twice", 32'(cmd_err), 32'd1);
        cmd(C_PRE, 2'd0, 13'h400);
        cmd(C_MRS, 2'd0, 13'h032);
        cmd(C_ACT, 2'd0, 13'd2);
        cmd(C_RD, 2'd0, 13'h006);
        cmd(C_RD, 2'd0, 13'h004);
        nop(); chk("t4 read mid burst", 32'(cmd_err), 32'd1);
        repeat (6) nop();

        // auto-refresh with open bank, self-refresh entry/exit
        cmd(C_REF, 2'd0, 13'h000);
        nop(); chk("t5 ref open", 32'(cmd_err), 32'd1);
        cmd(C_PRE, 2'd0, 13'h000);
        drive(C_REF, 2'd0, 13'h000, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(C_NOP, 2'd0, 13'h000, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t5 self_ref on", 32'(self_ref), 32'd1);
        repeat (9) drive(C_NOP, 2'd0, 13'h000, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t5 self_ref held", 32'(self_ref), 32'd1);
        nop();
        nop(); chk("t5 self_ref off", 32'(self_ref), 32'd0);

        // reset in the middle of a BL4 read
        cmd(C_ACT, 2'd0, 13'd2);
        cmd(C_RD, 2'd0, 13'h006);
        nop(); nop();
        nop(); chk("t6 beat0", dq_out, 32'hA000_000A);
        nop(); chk("t6 beat1", dq_out, 32'hB000_000B);
        n_rst = 1'b0;
        nop(); chk("t6 rv after rst", 32'(rd_valid), 32'd0);
        chk("t6 mode_set", 32'(mode_set), 32'd0);
        nop(); chk("t6 rv +1", 32'(rd_valid), 32'd0);
        nop(); chk("t6 rv +2", 32'(rd_valid), 32'd0);
        cmd(C_RD, 2'd0, 13'h006);
        nop(); chk("t6 read in init", 32'(cmd_err), 32'd1);

        // randomized traffic
        do_reset(2);
        cmd(C_MRS, 2'd0, 13'h032);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            b = 2'($urandom_range(0, 3));
            a = 13'($urandom_range(0, 15)) | (($urandom_range(0, 2) == 0) ? 13'h400 : 13'h000);
            if (r < 30)
                drive(C_NOP, b, a, $urandom(), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b1);
            else if (r < 42)
                cmd(C_ACT, b, 13'($urandom_range(0, 1)));
            else if (r < 57)
                drive(C_RD, b, a, $urandom(), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b1);
            else if (r < 72)
                drive(C_WR, b, a, $urandom(), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b1);
            else if (r < 80)
                cmd(C_PRE, b, ($urandom_range(0, 3) == 0) ? 13'h400 : 13'h000);
            else if (r < 84)
                cmd(C_REF, b, 13'h000);
            else if (r < 90)
                cmd(C_MRS, 2'd0, 13'($urandom_range(1, 3) << 4) | 13'($urandom_range(0, 4) & 6));
            else if (r < 92) begin
                drive(C_REF, 2'd0, 13'h000, $urandom(), 1'b0, 1'b0, 1'b0);
                repeat ($urandom_range(0, 4)) drive(C_NOP, 2'd0, 13'h0, $urandom(), 1'b0, 1'b0, 1'b0);
            end else if (r < 93)
                do_reset(1);
            else begin
                cmd(3'($urandom_range(0, 7)), b, a);
                cs_n = 1'b1;
            end
        end
        repeat (8) nop();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
